spmv_channel_array: RTL and testbench

Parametrised multi-channel sparse matrix–vector multiply-accumulate array for the SpMV datapath. Each of `CHANNELS` lanes pops (matrix value, vector value, row id) triples from its three input FIFOs, multiplies them, and merges consecutive products with the same row id into one partial sum. Completed sums from all lanes are arbitrated round-robin onto a single backpressured write port toward the result buffer. This block replaces the fixed-width, fixed-count channel bank: it adds run-length accumulation, flush control, an idle indicator, and output merging with backpressure.

---
 rtl/spmv_channel_array_if.sv | 44 ++++
 rtl/spmv_channel_array.sv | 212 +++++++++++++++++++++
 tb/tb_spmv_channel_array.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_channel_array_if.sv
// Port bundle for spmv_channel_array. It carries the per-lane input FIFO
// pop interfaces, flush control, the merged result write port and the idle flag.
// master: the side that drives the FIFOs and the result buffer.
// slave:  the channel array itself.
interface spmv_channel_array_if #(
  parameter int CHANNELS = 4,
  parameter int MAT_W    = 16,
  parameter int VEC_W    = 16,
  parameter int ROW_W    = 10,
  parameter int ACC_W    = 40
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [MAT_W*CHANNELS-1:0] matrix_val;
  logic [CHANNELS-1:0]       matrix_val_empty;
  logic [CHANNELS-1:0]       matrix_val_rd_en;
  logic [VEC_W*CHANNELS-1:0] vec_val;
  logic [CHANNELS-1:0]       vec_val_empty;
  logic [CHANNELS-1:0]       vec_val_rd_en;
  logic [ROW_W*CHANNELS-1:0] row_id_out;
  logic [CHANNELS-1:0]       row_id_empty;
  logic [CHANNELS-1:0]       row_id_rd_en;
  logic                      flush;
  logic                      wr_ready;
  logic                      wr_en;
  logic [ACC_W-1:0]          wr_data;
  logic [ROW_W-1:0]          wr_addr;
  logic [CH_W-1:0]           wr_ch;
  logic                      idle;

  modport master (
    output matrix_val, matrix_val_empty, vec_val, vec_val_empty,
           row_id_out, row_id_empty, flush, wr_ready,
    input  matrix_val_rd_en, vec_val_rd_en, row_id_rd_en,
           wr_en, wr_data, wr_addr, wr_ch, idle
  );

  modport slave (
    input  matrix_val, matrix_val_empty, vec_val, vec_val_empty,
           row_id_out, row_id_empty, flush, wr_ready,
    output matrix_val_rd_en, vec_val_rd_en, row_id_rd_en,
           wr_en, wr_data, wr_addr, wr_ch, idle
  );
endinterface

// File: rtl/spmv_channel_array.sv
// Multi-lane sparse matrix-vector multiply-accumulate array.
// Each lane pops (matrix, vector, row) triples and multiplies them. It then
// merges consecutive products that share a row into one partial sum.
// Finished sums are parked in a one-entry per-lane slot. A round-robin arbiter
// moves them into a single backpressured output register.
module spmv_channel_array #(
  parameter int CHANNELS = 4,
  parameter int MAT_W    = 16,
  parameter int VEC_W    = 16,
  parameter int ROW_W    = 10,
  parameter int ACC_W    = 40
) (
  input logic                clk,
  input logic                rst,
  spmv_channel_array_if.slave bus
);
  localparam int PROD_W = MAT_W + VEC_W;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Sign-extend a product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // Two's complement accumulate; wraps modulo 2^ACC_W with no saturation.
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction

  // Lane index k positions after base, wrapping at CHANNELS.
  function automatic logic [CH_W-1:0] lane_after(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNELS) s = s - CHANNELS;
    return CH_W'(s);
  endfunction

  logic signed [MAT_W-1:0]  mat_p0     [CHANNELS];
  logic signed [VEC_W-1:0]  vec_p0     [CHANNELS];
  logic        [ROW_W-1:0]  row_p0     [CHANNELS];
  logic        [CHANNELS-1:0] avail_p0, pop_p0;

  logic signed [PROD_W-1:0] prod_p1    [CHANNELS];
  logic        [ROW_W-1:0]  row_p1     [CHANNELS];
  logic        [CHANNELS-1:0] vld_p1;

  logic signed [ACC_W-1:0]  acc_p2     [CHANNELS];
  logic        [ROW_W-1:0]  acc_row_p2 [CHANNELS];
  logic        [CHANNELS-1:0] acc_vld_p2;

  logic signed [ACC_W-1:0]  slot_sum   [CHANNELS];
  logic        [ROW_W-1:0]  slot_row   [CHANNELS];
  logic        [CHANNELS-1:0] slot_full;

  logic [CHANNELS-1:0] same_row, hold, emit, flush_emit, fill, grant;

  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_idx, rr_ptr, rr_next;
  logic              out_free;
  logic              out_vld;
  logic [ACC_W-1:0]  out_data;
  logic [ROW_W-1:0]  out_addr;
  logic [CH_W-1:0]   out_ch;

  // ---- stage 0: FIFO heads ----
  // Unpack the lane heads and decide which lanes have a complete triple.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mat_p0[i] = bus.matrix_val[MAT_W*i +: MAT_W];
      vec_p0[i] = bus.vec_val[VEC_W*i +: VEC_W];
      row_p0[i] = bus.row_id_out[ROW_W*i +: ROW_W];
    end
    avail_p0 = ~bus.matrix_val_empty & ~bus.vec_val_empty & ~bus.row_id_empty;
  end

  // Per-lane run detection, stall and slot-fill decisions; hold only looks at
  // registered slot state so wr_ready never reaches the pop path.
  always_comb begin
    same_row   = '0;
    hold       = '0;
    emit       = '0;
    flush_emit = '0;
    fill       = '0;
    pop_p0     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      same_row[i]   = acc_vld_p2[i] && (row_p1[i] == acc_row_p2[i]);
      hold[i]       = slot_full[i] & vld_p1[i] & acc_vld_p2[i] & ~same_row[i];
      emit[i]       = vld_p1[i] & ~hold[i] & acc_vld_p2[i] & ~same_row[i];
      flush_emit[i] = bus.flush & ~vld_p1[i] & acc_vld_p2[i] & ~slot_full[i];
      fill[i]       = emit[i] | flush_emit[i];
      pop_p0[i]     = avail_p0[i] & ~hold[i] & rst;
    end
  end

  assign bus.matrix_val_rd_en = pop_p0;
  assign bus.vec_val_rd_en    = pop_p0;
  assign bus.row_id_rd_en     = pop_p0;

  // ---- stage 1: multiply ----
  // Stage-1 valid follows the pop unless the lane is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (!hold[i]) vld_p1[i] <= pop_p0[i];
    end
  end

  // Signed product and its row id, captured on pop.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (pop_p0[i]) begin
        prod_p1[i] <= PROD_W'(mat_p0[i]) * PROD_W'(vec_p0[i]);
        row_p1[i]  <= row_p0[i];
      end
    end
  end

  // ---- stage 2: run-length accumulate ----
  // The accumulator becomes valid on any consumed product and is cleared by a flush emission.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_vld_p2 <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (vld_p1[i] && !hold[i]) acc_vld_p2[i] <= 1'b1;
        else if (flush_emit[i])    acc_vld_p2[i] <= 1'b0;
      end
    end
  end

  // Add to the running sum on a row match; otherwise start a new run.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (vld_p1[i] && !hold[i]) begin
        acc_p2[i]     <= same_row[i] ? wrap_add(acc_p2[i], sext_prod(prod_p1[i]))
                                     : sext_prod(prod_p1[i]);
        acc_row_p2[i] <= row_p1[i];
      end
    end
  end

  // ---- lane slots ----
  // A slot fills on emission and is vacated when granted; the two never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_full <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (fill[i])       slot_full[i] <= 1'b1;
        else if (grant[i]) slot_full[i] <= 1'b0;
      end
    end
  end

  // Slot payload copied from the accumulator at the emission edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (fill[i]) begin
        slot_sum[i] <= acc_p2[i];
        slot_row[i] <= acc_row_p2[i];
      end
    end
  end

  // ---- output arbitration ----
  assign out_free = ~out_vld | bus.wr_ready;

  // Round-robin search from rr_ptr for the first full slot.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!gnt_vld && slot_full[lane_after(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = lane_after(rr_ptr, k);
      end
    end
    for (int i = 0; i < CHANNELS; i++)
      grant[i] = out_free & gnt_vld & (gnt_idx == CH_W'(i));
  end

  assign rr_next = (int'(gnt_idx) == CHANNELS - 1) ? '0 : CH_W'(int'(gnt_idx) + 1);

  // Output register: holds while stalled and reloads from the granted slot when free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      out_ch   <= '0;
      rr_ptr   <= '0;
    end else if (out_free) begin
      out_vld <= gnt_vld;
      if (gnt_vld) begin
        out_data <= slot_sum[gnt_idx];
        out_addr <= slot_row[gnt_idx];
        out_ch   <= gnt_idx;
        rr_ptr   <= rr_next;
      end
    end
  end

  assign bus.wr_en   = out_vld;
  assign bus.wr_data = out_data;
  assign bus.wr_addr = out_addr;
  assign bus.wr_ch   = out_ch;
  assign bus.idle    = ~|vld_p1 & ~|acc_vld_p2 & ~|slot_full & ~out_vld;
endmodule

// File: tb/tb_spmv_channel_array.sv
// Bench for spmv_channel_array. Software FIFOs feed the four lanes. A
// scoreboard queue holds expected (lane, row, sum) writes and is checked as
// the result port accepts each one.
module tb_spmv_channel_array;
  localparam int CH = 4, MAT_W = 16, VEC_W = 16, ROW_W = 10, ACC_W = 40, CH_W = 2;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spmv_channel_array_if #(.CHANNELS(CH), .MAT_W(MAT_W), .VEC_W(VEC_W),
                          .ROW_W(ROW_W), .ACC_W(ACC_W)) bus();
  spmv_channel_array #(.CHANNELS(CH), .MAT_W(MAT_W), .VEC_W(VEC_W),
                       .ROW_W(ROW_W), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int ch; int row; logic [ACC_W-1:0] data; } exp_t;
  typedef struct { int lane; int mat; int vec; int row; longint exp; } vec_t;

  exp_t exp_q[$];
  int   log_ch[$];
  int   n_checks = 0, n_fail = 0, n_writes = 0;

  logic [MAT_W-1:0] f_mat [CH][DEPTH];
  logic [VEC_W-1:0] f_vec [CH][DEPTH];
  logic [ROW_W-1:0] f_row [CH][DEPTH];
  int rp [CH];
  int wp [CH];
  logic [CH-1:0] gate = '1, toggle = '0;

  logic signed [ACC_W-1:0] m_acc [CH];
  int m_row [CH];
  bit m_vld [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_heads();
    logic [MAT_W*CH-1:0] m; logic [VEC_W*CH-1:0] v; logic [ROW_W*CH-1:0] r;
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++) begin
      m[MAT_W*i +: MAT_W] = f_mat[i][rp[i] % DEPTH];
      v[VEC_W*i +: VEC_W] = f_vec[i][rp[i] % DEPTH];
      r[ROW_W*i +: ROW_W] = f_row[i][rp[i] % DEPTH];
      e[i] = (rp[i] == wp[i]) || !gate[i];
    end
    bus.matrix_val = m; bus.vec_val = v; bus.row_id_out = r;
    bus.matrix_val_empty = e; bus.vec_val_empty = e; bus.row_id_empty = e;
  endtask

  // FIFO model: sample pops away from the edge, retire them at the edge, then present new heads.
  initial begin
    logic [CH-1:0] popm;
    for (int i = 0; i < CH; i++) begin rp[i] = 0; wp[i] = 0; end
    drive_heads();
    forever begin
      @(negedge clk);
      popm = bus.matrix_val_rd_en;
      check("rd_en_equal", {bus.vec_val_rd_en, bus.row_id_rd_en}, {popm, popm});
      check("pop_only_nonempty", popm & bus.matrix_val_empty, 0);
      @(posedge clk);
      for (int i = 0; i < CH; i++) if (popm[i]) rp[i]++;
      #2;
      for (int i = 0; i < CH; i++) if (toggle[i]) gate[i] = ~gate[i];
      drive_heads();
    end
  end

  // Result monitor: score every accepted write and check stability while stalled.
  initial begin
    bit stall_prev = 0;
    logic [ACC_W+ROW_W+CH_W-1:0] prev = '0;
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stall_prev) begin
          check("stall_wr_en", bus.wr_en, 1);
          check("stall_payload", {bus.wr_data, bus.wr_addr, bus.wr_ch}, prev);
        end
        if (bus.wr_en && bus.wr_ready) begin
          n_writes++;
          log_ch.push_back(int'(bus.wr_ch));
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].ch == int'(bus.wr_ch)) idx = k;
          if (idx < 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: ch=%0d addr=%0d data=%0h required=none",
                     bus.wr_ch, bus.wr_addr, bus.wr_data);
          end else begin
            check("wr_data", {24'b0, bus.wr_data}, {24'b0, exp_q[idx].data});
            check("wr_addr", bus.wr_addr, exp_q[idx].row);
            exp_q.delete(idx);
          end
        end
        stall_prev = bus.wr_en && !bus.wr_ready;
        prev = {bus.wr_data, bus.wr_addr, bus.wr_ch};
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic push_exp(input int ch, input int row, input logic [ACC_W-1:0] data);
    exp_t e;
    e.ch = ch; e.row = row; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send(input int l, input int m, input int v, input int r);
    f_mat[l][wp[l] % DEPTH] = MAT_W'(m);
    f_vec[l][wp[l] % DEPTH] = VEC_W'(v);
    f_row[l][wp[l] % DEPTH] = ROW_W'(r);
    wp[l]++;
  endtask

  // Send a triple and let the reference model form the expected run sums.
  task automatic feed(input int l, input int m, input int v, input int r);
    longint p;
    send(l, m, v, r);
    p = longint'(m) * longint'(v);
    if (m_vld[l] && m_row[l] == r) begin
      m_acc[l] = m_acc[l] + ACC_W'(p);
    end else begin
      if (m_vld[l]) push_exp(l, m_row[l], m_acc[l]);
      m_acc[l] = ACC_W'(p); m_row[l] = r; m_vld[l] = 1;
    end
  endtask

  task automatic model_flush();
    for (int l = 0; l < CH; l++) begin
      if (m_vld[l]) push_exp(l, m_row[l], m_acc[l]);
      m_vld[l] = 0;
    end
  endtask

  function automatic bit fifos_empty();
    for (int l = 0; l < CH; l++) if (rp[l] != wp[l]) return 0;
    return 1;
  endfunction

  task automatic wait_fifos(input int budget);
    int k = 0;
    while (!fifos_empty() && k < budget) begin tick(1); k++; end
    if (!fifos_empty()) begin
      n_checks++; n_fail++;
      $display("FAIL fifo_drain_timeout: actual=pending required=empty");
      for (int l = 0; l < CH; l++) rp[l] = wp[l];
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    wait_fifos(budget);
    tick(4);
    bus.flush = 1'b1;
    model_flush();
    while (exp_q.size() != 0 && k < budget) begin tick(1); k++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    tick(3);
    check("idle_after_drain", bus.idle, 1);
    bus.flush = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int base;
    tbl[0] = '{0, -32768, -32768, 10,  64'sd1073741824};
    tbl[1] = '{1,  32767, -32768, 11, -64'sd1073709056};
    tbl[2] = '{2,  32767,  32767, 12,  64'sd1073676289};
    tbl[3] = '{3,     -1,     -1, 13,  64'sd1};
    tbl[4] = '{0,      0,  -1234, 14,  64'sd0};
    tbl[5] = '{1,     -7,      6, 15, -64'sd42};
    for (int l = 0; l < CH; l++) begin m_vld[l] = 0; m_acc[l] = '0; m_row[l] = 0; end
    bus.flush = 1'b0;
    bus.wr_ready = 1'b0;

    // Reset state, with a triple already waiting on lane 0.
    feed(0, 2, 5, 3);
    tick(3);
    check("rst_rd_en", bus.matrix_val_rd_en, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_ch", bus.wr_ch, 0);
    check("rst_idle", bus.idle, 1);
    rst = 1'b1;

    // Two runs on lane 0, with the last one released by flush.
    bus.wr_ready = 1'b1;
    base = n_writes;
    feed(0, -1, 4, 3);
    feed(0, 7, 1, 5);
    drain(200);
    check("lane0_write_count", n_writes - base, 2);

    // Single-product runs across the multiplier corners.
    for (int i = 0; i < 6; i++) begin
      push_exp(tbl[i].lane, tbl[i].row, ACC_W'(tbl[i].exp));
      send(tbl[i].lane, tbl[i].mat, tbl[i].vec, tbl[i].row);
      drain(200);
    end

    // Round-robin order across lanes from a fresh pointer.
    rst = 1'b0; tick(2); rst = 1'b1;
    log_ch.delete();
    for (int l = 0; l < CH; l++) feed(l, 1, 1, 1);
    for (int l = 0; l < CH; l++) feed(l, 1, 1, 2);
    drain(200);
    check("rr_count", log_ch.size(), 8);
    for (int i = 0; i < log_ch.size() && i < 8; i++) check("rr_order", log_ch[i], i % 4);

    // Backpressure: lane 1 stalls behind a blocked output register.
    bus.wr_ready = 1'b0;
    base = n_writes;
    for (int r = 0; r < 10; r++) feed(1, r + 1, 3, r);
    tick(20);
    check("bp_wr_en", bus.wr_en, 1);
    check("bp_first_addr", bus.wr_addr, 0);
    check("bp_first_data", bus.wr_data, 3);
    check("bp_rd_en_low", bus.matrix_val_rd_en[1], 0);
    check("bp_lane1_pending", rp[1] != wp[1], 1);
    bus.wr_ready = 1'b1;
    drain(400);
    check("bp_write_count", n_writes - base, 10);

    // 1024 x 2^30 on one row wraps the 40-bit sum to zero.
    for (int k = 0; k < 1024; k++) send(3, -32768, -32768, 7);
    push_exp(3, 7, '0);
    drain(3000);

    // Gappy lane-2 stream: only the row-4 run is written before flush.
    toggle[2] = 1'b1;
    base = n_writes;
    feed(2, 3, -5, 4); feed(2, 3, -5, 4); feed(2, 3, -5, 4); feed(2, 2, 2, 9);
    wait_fifos(400);
    tick(10);
    check("gap_writes_before_flush", n_writes - base, 1);
    check("gap_row9_pending", exp_q.size(), 0);
    drain(400);
    check("gap_writes_after_flush", n_writes - base, 2);
    toggle[2] = 1'b0; gate = '1;

    // Asynchronous reset while sums are held and the output is stalled.
    bus.wr_ready = 1'b0;
    for (int l = 0; l < CH; l++) begin
      feed(l, 1, 2, l); feed(l, 1, 2, l + 8); feed(l, 1, 1, l + 20);
    end
    tick(12);
    check("pre_rst_wr_en", bus.wr_en, 1);
    check("pre_rst_idle", bus.idle, 0);
    #2 rst = 1'b0;
    exp_q.delete();
    for (int l = 0; l < CH; l++) begin rp[l] = wp[l]; m_vld[l] = 0; end
    #1;
    check("async_rst_wr_en", bus.wr_en, 0);
    check("async_rst_wr_data", bus.wr_data, 0);
    check("async_rst_wr_addr", bus.wr_addr, 0);
    check("async_rst_wr_ch", bus.wr_ch, 0);
    check("async_rst_idle", bus.idle, 1);
    check("async_rst_rd_en", bus.matrix_val_rd_en, 0);
    tick(2);
    rst = 1'b1;
    bus.wr_ready = 1'b1;
    bus.flush = 1'b1;
    base = n_writes;
    tick(10);
    check("post_rst_no_write", n_writes - base, 0);
    check("post_rst_idle", bus.idle, 1);
    bus.flush = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
